// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, digit patterns and a
// pattern-to-digit decode helper.
`default_nettype none

package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } digit_t;

  function automatic digit_t decode_seg(input logic [6:0] pattern);
    digit_t res;
    res = '{valid: 1'b1, digit: 4'd0};
    case (pattern)
      SEG_0:   res.digit = 4'd0;
      SEG_1:   res.digit = 4'd1;
      SEG_2:   res.digit = 4'd2;
      SEG_3:   res.digit = 4'd3;
      SEG_4:   res.digit = 4'd4;
      SEG_5:   res.digit = 4'd5;
      SEG_6:   res.digit = 4'd6;
      SEG_7:   res.digit = 4'd7;
      SEG_8:   res.digit = 4'd8;
      SEG_9:   res.digit = 4'd9;
      default: res.valid = 1'b0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder: returns the digit 0-9 and a flag
// that is low for any pattern that is not a digit (blank included).
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  digit_t res;

  always_comb begin
    res   = decode_seg(pattern);
    digit = res.digit;
    valid = res.valid;
  end

endmodule

`default_nettype wire

// File: rtl/seg7_reader.sv
// Recovers the digit shown on a 7-segment bus: synchronize, de-glitch,
// decode, and check the count-up-and-wrap sequence of the display counter.
`default_nettype none

module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16,
  parameter int MAX_DIGIT     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       pattern_invalid,
  output logic       seq_error,
  output logic [7:0] err_count
);

  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);
  localparam logic [3:0]       MAX_D      = 4'(MAX_DIGIT);

  logic [6:0]       s1;
  logic [6:0]       s2;
  logic [6:0]       s2_d;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       last_pattern;
  logic [3:0]       prev;
  logic             have_prev;

  logic [3:0]       dec_digit;
  logic             dec_valid;
  logic [3:0]       expected;
  logic             accept;

  seg7_decode u_decode (
    .pattern (s2),
    .digit   (dec_digit),
    .valid   (dec_valid)
  );

  // A digit above MAX_DIGIT still has a successor: plain +1 with 9 wrapping to 0.
  always_comb begin
    if (prev == MAX_D || prev == 4'd9) begin
      expected = 4'd0;
    end else begin
      expected = prev + 4'd1;
    end
  end

  assign accept = (cnt == STABLE_LIM - CNT_W'(1)) && (s2 == s2_d) &&
                  (s2 != last_pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1              <= '0;
      s2              <= '0;
      s2_d            <= '0;
      cnt             <= '0;
      last_pattern    <= 7'h7F;
      prev            <= '0;
      have_prev       <= 1'b0;
      digit_out       <= '0;
      digit_valid     <= 1'b0;
      pattern_invalid <= 1'b0;
      seq_error       <= 1'b0;
      err_count       <= '0;
    end else begin
      s1   <= seg_in;
      s2   <= s1;
      s2_d <= s2;

      // s1/s2 are next cycle's s2/s2_d, so the count is ready as soon as
      // s2 has been stable for STABLE_CYCLES synchronized cycles.
      if (s1 != s2) begin
        cnt <= '0;
      end else if (cnt != STABLE_LIM) begin
        cnt <= cnt + CNT_W'(1);
      end

      digit_valid     <= 1'b0;
      pattern_invalid <= 1'b0;
      seq_error       <= 1'b0;

      if (accept) begin
        last_pattern <= s2;
        if (dec_valid) begin
          digit_out   <= dec_digit;
          digit_valid <= 1'b1;
          if (have_prev && dec_digit != expected) begin
            seq_error <= 1'b1;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
          end
          prev      <= dec_digit;
          have_prev <= 1'b1;
        end else begin
          pattern_invalid <= 1'b1;
          have_prev       <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: run-length reference model checked
// every cycle, plus table-driven sequences and hand-written corner cases.
`default_nettype none

module tb_seg7_reader;

  localparam int S    = 4;
  localparam int MAXD = 6;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       pattern_invalid;
  logic       seq_error;
  logic [7:0] err_count;

  seg7_reader #(.STABLE_CYCLES(S), .CNT_W(16), .MAX_DIGIT(MAXD)) dut (
    .clk             (clk),
    .rst             (rst),
    .seg_in          (seg_in),
    .digit_out       (digit_out),
    .digit_valid     (digit_valid),
    .pattern_invalid (pattern_invalid),
    .seq_error       (seq_error),
    .err_count       (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_checks = 0;
  int n_err    = 0;

  // reference model state
  int         cyc = 0;
  logic [6:0] m_run_val;
  int         m_run_len;
  int         m_due;
  logic [6:0] m_pend;
  logic [6:0] m_last;
  int         m_prev;
  bit         m_have;
  int         m_digit;
  int         m_err;
  bit         m_dv, m_pi, m_se;

  int n_dv, n_pi, n_se;

  typedef struct {
    logic [6:0] pat;
    int hold;
    int dv;
    int pi;
    int se;
    int dig;
    int err;
  } vec_t;

  vec_t vecs [18];

  function automatic int ref_decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run_val = 7'h00;
    m_run_len = 2;
    m_due     = -1;
    m_pend    = 7'h00;
    m_last    = 7'h7F;
    m_prev    = 0;
    m_have    = 0;
    m_digit   = 0;
    m_err     = 0;
    m_dv      = 0;
    m_pi      = 0;
    m_se      = 0;
  endtask

  task automatic tick();
    int d;
    int exp_d;
    @(posedge clk);
    cyc++;
    m_dv = 0; m_pi = 0; m_se = 0;
    if (m_due == cyc) begin
      m_due = -1;
      if (m_pend != m_last) begin
        m_last = m_pend;
        d = ref_decode(m_pend);
        if (d >= 0) begin
          m_dv = 1;
          if (m_have) begin
            exp_d = (m_prev == MAXD || m_prev == 9) ? 0 : m_prev + 1;
            if (d != exp_d) begin
              m_se = 1;
              if (m_err < 255) m_err++;
            end
          end
          m_digit = d;
          m_prev  = d;
          m_have  = 1;
        end else begin
          m_pi   = 1;
          m_have = 0;
        end
      end
    end
    if (seg_in == m_run_val) begin
      if (m_run_len < S) begin
        m_run_len++;
        if (m_run_len == S) begin
          m_due  = cyc + 2;
          m_pend = m_run_val;
        end
      end
    end else begin
      m_run_val = seg_in;
      m_run_len = 1;
    end
    #1;
    check("cycle {digit,dv,pi,se,err}",
          {17'd0, digit_out, digit_valid, pattern_invalid, seq_error, err_count},
          {17'd0, 4'(m_digit), m_dv, m_pi, m_se, 8'(m_err)});
    n_dv += int'(digit_valid);
    n_pi += int'(pattern_invalid);
    n_se += int'(seq_error);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("reset_outputs_zero",
          {17'd0, digit_out, digit_valid, pattern_invalid, seq_error, err_count}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first;
    rst    = 1'b0;
    seg_in = 7'h00;
    model_reset();

    vecs[0]  = '{7'h06, 10, 1, 0, 0, 1, 0};
    vecs[1]  = '{7'h5B, 10, 1, 0, 0, 2, 0};
    vecs[2]  = '{7'h4F, 10, 1, 0, 0, 3, 0};
    vecs[3]  = '{7'h66, 10, 1, 0, 0, 4, 0};
    vecs[4]  = '{7'h6D, 10, 1, 0, 0, 5, 0};
    vecs[5]  = '{7'h7D, 10, 1, 0, 0, 6, 0};
    vecs[6]  = '{7'h3F, 10, 1, 0, 0, 0, 0};
    vecs[7]  = '{7'h06, 10, 1, 0, 0, 1, 0};
    vecs[8]  = '{7'h5B,  2, 0, 0, 0, 1, 0};
    vecs[9]  = '{7'h06, 10, 0, 0, 0, 1, 0};
    vecs[10] = '{7'h5B, 10, 1, 0, 0, 2, 0};
    vecs[11] = '{7'h66, 10, 1, 0, 1, 4, 1};
    vecs[12] = '{7'h6D, 10, 1, 0, 0, 5, 1};
    vecs[13] = '{7'h00, 10, 0, 1, 0, 5, 1};
    vecs[14] = '{7'h5B, 10, 1, 0, 0, 2, 1};
    vecs[15] = '{7'h7F, 10, 1, 0, 1, 8, 2};
    vecs[16] = '{7'h6F, 10, 1, 0, 0, 9, 2};
    vecs[17] = '{7'h3F, 10, 1, 0, 0, 0, 2};

    #12;
    seg_in = 7'h3F;
    do_reset();

    // first acceptance latency: E0 is the first edge after release
    first = -1;
    n_dv = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (digit_valid && first < 0) first = i;
    end
    check("latency_edge", first, 1 + S + 1);
    check("latency_digit", digit_out, 0);
    check("latency_pulses", n_dv, 1);

    for (int v = 0; v < 18; v++) begin
      n_dv = 0; n_pi = 0; n_se = 0;
      hold(vecs[v].pat, vecs[v].hold);
      check($sformatf("vec%0d_dv", v), n_dv, vecs[v].dv);
      check($sformatf("vec%0d_pi", v), n_pi, vecs[v].pi);
      check($sformatf("vec%0d_se", v), n_se, vecs[v].se);
      check($sformatf("vec%0d_digit", v), digit_out, vecs[v].dig);
      check($sformatf("vec%0d_err", v), err_count, vecs[v].err);
    end

    // 260 sequence breaks alternating 2 and 0 after a 0
    n_se = 0;
    for (int i = 0; i < 260; i++) hold((i % 2 == 0) ? 7'h5B : 7'h3F, 6);
    check("sat_breaks", n_se, 260);
    check("sat_err_count", err_count, 255);
    n_se = 0;
    hold(7'h5B, 6);
    check("sat_hold_se", n_se, 1);
    check("sat_hold_err", err_count, 255);

    // reset while the filter is part-way through a new pattern
    n_dv = 0; n_pi = 0;
    hold(7'h4F, 3);
    check("midfilter_no_pulse", n_dv + n_pi, 0);
    do_reset();
    first = -1;
    n_dv = 0; n_pi = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if ((digit_valid || pattern_invalid) && first < 0) first = i;
    end
    check("midfilter_edge", first, 1 + S + 1);
    check("midfilter_pulses", n_dv + n_pi, 1);
    check("midfilter_digit", digit_out, 3);
    check("midfilter_err", err_count, 0);

    // randomized patterns and hold lengths against the model
    for (int k = 0; k < 250; k++) begin
      int r;
      logic [6:0] p;
      r = $urandom_range(0, 12);
      if (r < 10) p = seg_tab[r];
      else p = 7'($urandom_range(0, 127));
      hold(p, $urandom_range(1, 8));
    end
    hold(seg_in, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
